// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN image path: buffer geometry, arbiter
// states and the buffer status code that controller_fsm decodes.
package bnn_pkg;

   localparam int IMG_BYTE_SIZE = 113;
   localparam int IMG_ADDR_W    = 7;
   localparam int IMG_DATA_W    = 8;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_CLEAR = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      BUF_ST_EMPTY    = 2'd0,
      BUF_ST_PARTIAL  = 2'd1,
      BUF_ST_FULL     = 2'd2,
      BUF_ST_CLEARING = 2'd3
   } buf_status_t;

   // Collapses the arbiter status flags into the single code the controller branches on.
   function automatic buf_status_t buf_status(input logic full, input logic empty);
      if (full)
         return BUF_ST_FULL;
      else if (empty)
         return BUF_ST_EMPTY;
      else
         return BUF_ST_PARTIAL;
   endfunction

endpackage

// File: rtl/img_buf_arbiter.sv
// Owns the single-port image RAM: appends SPI bytes, serves BNN reads with a
// one-cycle starvation bound, and zeroes the whole buffer on clear.
module img_buf_arbiter
   import bnn_pkg::*;
#(
   parameter int DEPTH  = IMG_BYTE_SIZE,
   parameter int ADDR_W = IMG_ADDR_W,
   parameter int DATA_W = IMG_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              clear,
   output logic              buffer_full,
   output logic              buffer_empty,
   output logic              overflow,
   output logic [ADDR_W-1:0] fill_count,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] fill_q, fill_d;
   logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
   logic              ovf_q, ovf_d;
   logic              rd_starve_q, rd_starve_d;
   logic              rd_valid_q;
   logic              rd_oob_q;
   logic              full;

   assign full = (fill_q == DEPTH_A);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      sweep_cnt_d = sweep_cnt_q;
      ovf_d       = ovf_q;
      rd_starve_d = 1'b0;
      wr_ready    = 1'b0;
      rd_grant    = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;

      case (state_q)
         ARB_IDLE: begin
            if (clear) begin
               state_d     = ARB_CLEAR;
               wr_ptr_d    = '0;
               fill_d      = '0;
               sweep_cnt_d = '0;
               ovf_d       = 1'b0;
            end else begin
               wr_ready = !full && !rd_starve_q;
               if (wr_req && wr_ready) begin
                  mem_we      = 1'b1;
                  mem_addr    = wr_ptr_q;
                  mem_wdata   = wr_data;
                  wr_ptr_d    = wr_ptr_q + 1'b1;
                  fill_d      = fill_q + 1'b1;
                  // A read that loses to this write jumps the queue next cycle.
                  rd_starve_d = rd_req;
               end else begin
                  if (wr_req && full)
                     ovf_d = 1'b1;
                  if (rd_req) begin
                     rd_grant = 1'b1;
                     mem_addr = rd_addr;
                  end
               end
            end
         end

         ARB_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = sweep_cnt_q;
            if (sweep_cnt_q == LAST_A) begin
               state_d     = ARB_IDLE;
               sweep_cnt_d = '0;
            end else begin
               sweep_cnt_d = sweep_cnt_q + 1'b1;
            end
         end

         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         sweep_cnt_q <= '0;
         ovf_q       <= 1'b0;
         rd_starve_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_oob_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         sweep_cnt_q <= sweep_cnt_d;
         ovf_q       <= ovf_d;
         rd_starve_q <= rd_starve_d;
         rd_valid_q  <= rd_grant;
         // Addresses beyond the fill level may hold stale or unswept bytes; mask them.
         if (rd_grant)
            rd_oob_q <= (rd_addr >= fill_q);
      end
   end

   assign rd_valid     = rd_valid_q;
   assign rd_data      = (rd_valid_q && !rd_oob_q) ? mem_rdata : '0;
   assign buffer_full  = full;
   assign buffer_empty = (fill_q == '0) && (state_q == ARB_IDLE);
   assign overflow     = ovf_q;
   assign fill_count   = fill_q;

endmodule
